// File: rtl/instr_sequencer.sv
// Instruction fetch/sequencing stage: loadable program store plus PC, issuing
// each instruction to the core for a fixed hold window (run, single-step, halt).
module instr_sequencer #(
    parameter int unsigned IW          = 11,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned AW          = 4,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [IW-1:0] load_data,
    input  logic          start,
    input  logic          step,
    input  logic          halt_req,
    input  logic [AW-1:0] last_addr,
    output logic [IW-1:0] instruction,
    output logic          instr_valid,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          done
);

    localparam int unsigned HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [IW-1:0]   instr_q, instr_d;
    logic            valid_q, valid_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [HCW-1:0]  hold_q, hold_d;
    logic [AW-1:0]   last_q, last_d;
    logic            halt_q, halt_d;
    logic [IW-1:0]   mem_q [DEPTH];
    logic [IW-1:0]   mem_d [DEPTH];

    logic [AW-1:0]   pc_inc;
    logic            hold_end;
    logic            halt_now;

    // Next-state and output computation
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        done_d   = done_q;
        hold_d   = hold_q;
        last_d   = last_q;
        halt_d   = halt_q;
        mem_d    = mem_q;
        pc_inc   = pc_q + AW'(1);
        hold_end = (hold_q == HOLD_LAST);
        halt_now = halt_q | halt_req;

        case (state_q)
            IDLE, DONE: begin
                instr_d = '0;
                valid_d = 1'b0;
                halt_d  = 1'b0;
                if (load_en) begin
                    mem_d[load_addr] = load_data;
                    if (state_q == DONE) begin
                        done_d  = 1'b0;
                        state_d = IDLE;
                    end
                end else if (start) begin
                    state_d = RUN;
                    pc_d    = '0;
                    last_d  = last_addr;
                    instr_d = mem_q[0];
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    hold_d  = '0;
                end else if (step) begin
                    state_d = STEP;
                    instr_d = mem_q[pc_q];
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    hold_d  = '0;
                end
            end
            RUN: begin
                hold_d = hold_q + HCW'(1);
                halt_d = halt_now;
                if (hold_end) begin
                    // Finishing the program wins over a pending halt
                    if (pc_q == last_q) begin
                        state_d = DONE;
                        instr_d = '0;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        halt_d  = 1'b0;
                    end else if (halt_now) begin
                        state_d = IDLE;
                        pc_d    = pc_inc;
                        instr_d = '0;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        halt_d  = 1'b0;
                    end else begin
                        pc_d    = pc_inc;
                        instr_d = mem_q[pc_inc];
                        hold_d  = '0;
                    end
                end
            end
            STEP: begin
                hold_d = hold_q + HCW'(1);
                if (hold_end) begin
                    state_d = IDLE;
                    pc_d    = pc_inc;
                    instr_d = '0;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hold_q  <= '0;
            last_q  <= '0;
            halt_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
            halt_q  <= halt_d;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

    assign instruction = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: main instance with HOLD_CYCLES=2 and a
// second instance with HOLD_CYCLES=1 for the single-cycle hold case.
module tb_instr_sequencer;

    logic        clk;
    logic        reset_n;
    logic        load_en, start, step, halt_req;
    logic [3:0]  load_addr, last_addr;
    logic [10:0] load_data;
    logic [10:0] instruction;
    logic        instr_valid, busy, done;
    logic [3:0]  pc;

    logic        l1_en, s1_start, s1_step, s1_halt;
    logic [3:0]  l1_addr, s1_last;
    logic [10:0] l1_data;
    logic [10:0] instr1;
    logic        valid1, busy1, done1;
    logic [3:0]  pc1;

    int checks = 0;
    int errors = 0;

    logic [10:0] prog [8] = '{11'h101, 11'h202, 11'h303, 11'h404,
                              11'h505, 11'h606, 11'h707, 11'h708};

    instr_sequencer #(.IW(11), .DEPTH(16), .AW(4), .HOLD_CYCLES(2)) u_dut (
        .clk(clk), .reset_n(reset_n), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .start(start), .step(step), .halt_req(halt_req),
        .last_addr(last_addr), .instruction(instruction), .instr_valid(instr_valid),
        .pc(pc), .busy(busy), .done(done)
    );

    instr_sequencer #(.IW(11), .DEPTH(16), .AW(4), .HOLD_CYCLES(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .load_en(l1_en), .load_addr(l1_addr),
        .load_data(l1_data), .start(s1_start), .step(s1_step), .halt_req(s1_halt),
        .last_addr(s1_last), .instruction(instr1), .instr_valid(valid1),
        .pc(pc1), .busy(busy1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] a, input logic [10:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        tick();
        load_en = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        load_en = 0; start = 0; step = 0; halt_req = 0; load_addr = 0; load_data = 0; last_addr = 0;
        l1_en = 0; s1_start = 0; s1_step = 0; s1_halt = 0; l1_addr = 0; l1_data = 0; s1_last = 0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        checks++;
        if ({instruction, instr_valid, pc, busy, done} !== 18'd0) begin
            errors++;
            $display("FAIL reset_state: got instr=%h valid=%b pc=%0d busy=%b done=%b, want all 0",
                     instruction, instr_valid, pc, busy, done);
        end
    endtask

    task automatic test_run();
        for (int i = 0; i < 4; i++) load(4'(i), prog[i]);
        last_addr = 4'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (instruction !== prog[i/2] || instr_valid !== 1'b1 || pc !== 4'(i/2) || busy !== 1'b1) begin
                errors++;
                $display("FAIL run_issue[%0d]: got instr=%h valid=%b pc=%0d busy=%b, want instr=%h valid=1 pc=%0d busy=1",
                         i, instruction, instr_valid, pc, busy, prog[i/2], i/2);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || instr_valid !== 1'b0 || pc !== 4'd3 || busy !== 1'b0 || instruction !== 11'h0) begin
            errors++;
            $display("FAIL run_done: got done=%b valid=%b pc=%0d busy=%b instr=%h, want done=1 valid=0 pc=3 busy=0 instr=0",
                     done, instr_valid, pc, busy, instruction);
        end
    endtask

    task automatic test_hold1();
        l1_en = 1'b1; l1_addr = 4'd0; l1_data = 11'h5A5;
        tick();
        l1_en = 1'b0; s1_last = 4'd0; s1_start = 1'b1;
        tick();
        s1_start = 1'b0;
        checks++;
        if (instr1 !== 11'h5A5 || valid1 !== 1'b1 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL hold1_issue: got instr=%h valid=%b busy=%b, want 5a5 1 1", instr1, valid1, busy1);
        end
        tick();
        checks++;
        if (valid1 !== 1'b0 || done1 !== 1'b1 || pc1 !== 4'd0 || instr1 !== 11'h0) begin
            errors++;
            $display("FAIL hold1_done: got valid=%b done=%b pc=%0d instr=%h, want 0 1 0 0", valid1, done1, pc1, instr1);
        end
    endtask

    task automatic test_halt();
        for (int i = 4; i < 8; i++) load(4'(i), prog[i]);
        last_addr = 4'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        checks++;
        if (instruction !== 11'h303 || instr_valid !== 1'b1 || pc !== 4'd2) begin
            errors++;
            $display("FAIL halt_window: got instr=%h valid=%b pc=%0d, want 303 1 2", instruction, instr_valid, pc);
        end
        tick();
        checks++;
        if (pc !== 4'd3 || busy !== 1'b0 || done !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL halt_idle: got pc=%0d busy=%b done=%b valid=%b, want 3 0 0 0", pc, busy, done, instr_valid);
        end
        step = 1'b1;
        tick();
        step = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (instruction !== 11'h404 || instr_valid !== 1'b1 || busy !== 1'b1 || pc !== 4'd3) begin
                errors++;
                $display("FAIL step_issue[%0d]: got instr=%h valid=%b busy=%b pc=%0d, want 404 1 1 3",
                         i, instruction, instr_valid, busy, pc);
            end
            tick();
        end
        checks++;
        if (pc !== 4'd4 || instr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL step_end: got pc=%0d valid=%b busy=%b done=%b, want 4 0 0 0", pc, instr_valid, busy, done);
        end
    endtask

    task automatic test_halt_last();
        last_addr = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        tick();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || pc !== 4'd1 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL halt_last: got done=%b busy=%b pc=%0d valid=%b, want 1 0 1 0", done, busy, pc, instr_valid);
        end
    endtask

    task automatic test_wrap_and_priority();
        load(4'd15, 11'h7FF);
        for (int i = 0; i < 14; i++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            repeat (2) tick();
        end
        checks++;
        if (pc !== 4'd15) begin
            errors++;
            $display("FAIL step_to_15: got pc=%0d, want 15", pc);
        end
        step = 1'b1;
        tick();
        step = 1'b0;
        checks++;
        if (instruction !== 11'h7FF || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL step_15_issue: got instr=%h valid=%b, want 7ff 1", instruction, instr_valid);
        end
        repeat (2) tick();
        checks++;
        if (pc !== 4'd0 || instr_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL pc_wrap: got pc=%0d valid=%b busy=%b, want 0 0 0", pc, instr_valid, busy);
        end
        load_en = 1'b1; load_addr = 4'd0; load_data = 11'h0AB; start = 1'b1;
        tick();
        load_en = 1'b0; start = 1'b0;
        checks++;
        if (busy !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL load_over_start: got busy=%b valid=%b, want 0 0", busy, instr_valid);
        end
        step = 1'b1;
        tick();
        step = 1'b0;
        checks++;
        if (instruction !== 11'h0AB || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL load_written: got instr=%h valid=%b, want 0ab 1", instruction, instr_valid);
        end
        repeat (2) tick();
    endtask

    task automatic test_reset_mid_run();
        last_addr = 4'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        checks++;
        if (pc !== 4'd5 || instruction !== 11'h606) begin
            errors++;
            $display("FAIL pre_reset: got pc=%0d instr=%h, want 5 606", pc, instruction);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({instruction, instr_valid, pc, busy, done} !== 18'd0) begin
            errors++;
            $display("FAIL async_reset: got instr=%h valid=%b pc=%0d busy=%b done=%b, want all 0",
                     instruction, instr_valid, pc, busy, done);
        end
        tick();
        reset_n = 1'b1;
        tick();
        start = 1'b1; last_addr = 4'd3;
        tick();
        start = 1'b0;
        checks++;
        if (instruction !== 11'h000 || instr_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL store_cleared: got instr=%h valid=%b busy=%b, want 000 1 1", instruction, instr_valid, busy);
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_hold1();
        test_halt();
        test_halt_last();
        test_wrap_and_priority();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Instruction fetch/sequencing stage directly upstream of the CPU core; drives the core's 11-bit instruction input.
- Holds a small loadable program store and a program counter.
- Issues instructions one at a time, each held stable for a fixed number of cycles so the core can complete its RAM/ALU work.
- Supports run-to-end, single-step and halt.

Parameters:
- IW, 11, instruction width.
- DEPTH, 16, program store entries.
- AW, 4, program counter / address width (DEPTH = 2^AW).
- HOLD_CYCLES, 2, cycles each instruction is held on the output; legal range >= 1.

Ports:
- clk  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- load_en  input  1  write load_data into program store at load_addr.
- load_addr  input  AW  program store write address.
- load_data  input  IW  program store write data.
- start  input  1  begin run from address 0.
- step  input  1  issue a single instruction at current pc.
- halt_req  input  1  stop a run after the current instruction.
- last_addr  input  AW  address of final instruction of the program.
- instruction  output  IW  instruction to the core.
- instr_valid  output  1  instruction output is live.
- pc  output  AW  current program counter.
- busy  output  1  high in RUN or STEP.
- done  output  1  run reached last_addr.

Behaviour:
- Reset (asynchronous, active-low on reset_n):
  - State -> IDLE.
  - Clears pc, instruction, instr_valid, busy, done, hold counter, the latched last_addr and all program store entries to 0.
  - Reset asserted mid-run aborts the run immediately.
- All outputs are registered.
- States: IDLE, RUN, STEP, DONE.
- IDLE / DONE:
  - instruction = 0, instr_valid = 0.
  - Command priority: load_en > start > step.
  - load_en: mem[load_addr] <= load_data. In DONE it also clears done and moves to IDLE. load_en is ignored in RUN/STEP.
  - start (sampled at edge E):
    - At E: state -> RUN, pc <= 0, last_addr latched, instruction <= mem[0], instr_valid <= 1, busy <= 1, done <= 0, hold_cnt <= 0.
  - step: state -> STEP, instruction <= mem[pc], instr_valid <= 1, busy <= 1, done <= 0, hold_cnt <= 0.
- RUN:
  - Each instruction stays on the output for exactly HOLD_CYCLES cycles; hold_cnt increments every cycle.
  - At the edge where hold_cnt == HOLD_CYCLES-1, one of three outcomes:
    - pc == latched last_addr -> DONE: instr_valid 0, instruction 0, busy 0, done 1. pc stays at last_addr.
    - Else, halt_pending set -> IDLE: pc <= pc+1, instr_valid 0, instruction 0, busy 0.
    - Else: pc <= pc+1, instruction <= mem[pc+1], hold_cnt <= 0. Back-to-back issue with no bubble.
  - halt_req is sampled in any RUN cycle and latched into halt_pending, cleared on leaving RUN.
  - Completing the run takes priority over halting: if the current pc == last_addr, the block goes to DONE, not IDLE.
  - start, step and load_en are ignored in RUN.
- STEP:
  - Holds the instruction for HOLD_CYCLES cycles.
  - At the end of the window: pc <= pc+1 (wraps DEPTH-1 -> 0), return to IDLE, instr_valid 0, instruction 0, busy 0.
  - last_addr is not consulted and done is not set.
  - start, step, halt_req and load_en are ignored in STEP.
- last_addr = 0 is a legal one-instruction program.
- A run always restarts at address 0. step resumes from the current pc, including after a halt.
- Commands are level-sampled. A held start re-triggers a new run the cycle after DONE is entered.

Test Plan:
- Reset, then load mem[0..3] = 11'h101, 11'h202, 11'h303, 11'h404, last_addr = 3, pulse start -> instruction shows 101, 202, 303, 404, each for 2 cycles with instr_valid = 1; then done = 1, instr_valid = 0, pc = 3.
- HOLD_CYCLES = 1, last_addr = 0, start -> exactly one cycle of mem[0] valid, then DONE.
- Run with last_addr = 7, assert halt_req during the pc = 2 window -> mem[2] completes its 2 cycles, then IDLE with pc = 3, busy = 0, done = 0; step -> mem[3] issued for 2 cycles, pc = 4.
- halt_req asserted during the last_addr instruction -> DONE with done = 1, not IDLE.
- Step from pc = 15 -> mem[15] issued, pc wraps to 0. Same cycle load_en = 1 and start = 1 in IDLE -> write performed, run not started.
- Assert reset_n low mid-run at pc = 5 -> outputs cleared asynchronously before the next edge; after release, a start issues mem[0] = 0 (store cleared).
